dac_stream_ctrl: RTL and testbench

DAC_STREAM_CTRL -- requirements
Module: dac_stream_ctrl

---
 rtl/dac_stream_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dac_stream_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl
// Buffers samples from the core in a small FIFO and plays them out to a
// multi-channel DAC at a programmable rate. Each playback tick pops one entry
// and loads it into the register of the channel it was tagged with.
//
// Ports
//   CLK           : PLL output clock
//   reset         : asynchronous active-low reset
//   in_valid      : sample offered by the core
//   in_ready      : FIFO has room (level < DEPTH)
//   in_data       : sample value
//   in_ch         : target channel of the sample
//   enable        : playback run; when low the tick counter idles at 0
//   rate_div      : playback period is rate_div+1 cycles
//   underrun_zero : 1 = zero all channels on underrun, 0 = hold them
//   clr_flags     : clears underrun and bad_ch
//   D_OUT         : registered channel values, channel k at [k*DATA_W +: DATA_W]
//   out_strobe    : one-cycle update pulse per channel
//   level         : FIFO occupancy
//   underrun      : sticky, a tick found the FIFO empty
//   bad_ch        : sticky, an accepted sample addressed a missing channel
module dac_stream_ctrl #(
    parameter int DATA_W = 10,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     underrun_zero,
    input  logic                     clr_flags,
    output logic [NUM_CH*DATA_W-1:0] D_OUT,
    output logic [NUM_CH-1:0]        out_strobe,
    output logic [LVL_W-1:0]         level,
    output logic                     underrun,
    output logic                     bad_ch
);

    logic [DATA_W-1:0]        r_mem_data [DEPTH];
    logic [CH_W-1:0]          r_mem_ch   [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [LVL_W-1:0]         r_level;
    logic [DIV_W-1:0]         r_cnt;
    logic [NUM_CH*DATA_W-1:0] r_dout;
    logic [NUM_CH-1:0]        r_strobe;
    logic                     r_underrun;
    logic                     r_bad_ch;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_ch_ok;
    logic                     w_push;
    logic                     w_bad;
    logic                     w_tick;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_under;
    logic [DATA_W-1:0]        w_head_data;
    logic [CH_W-1:0]          w_head_ch;

    // Readiness depends only on the registered level, so a pop in the same
    // cycle never frees a slot for a push into a full FIFO.
    assign w_ready     = (r_level < LVL_W'(DEPTH));
    assign w_accept    = in_valid & w_ready;
    // One extra bit so NUM_CH itself is representable in the compare.
    assign w_ch_ok     = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
    assign w_push      = w_accept & w_ch_ok;
    assign w_bad       = w_accept & ~w_ch_ok;
    assign w_tick      = enable & (r_cnt == rate_div);
    assign w_empty     = (r_level == '0);
    assign w_pop       = w_tick & ~w_empty;
    assign w_under     = w_tick & w_empty;
    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_head_ch   = r_mem_ch[r_rd_ptr];

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_ch[r_wr_ptr]   <= in_ch;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A count above a freshly lowered rate_div falls back to 0 silently;
    // only the equal case is a tick.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt >= rate_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_dout   <= '0;
            r_strobe <= '0;
        end else begin
            r_strobe <= '0;
            if (w_pop) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (w_head_ch == CH_W'(k)) begin
                        r_dout[k*DATA_W +: DATA_W] <= w_head_data;
                        r_strobe[k]                <= 1'b1;
                    end
                end
            end else if (w_under && underrun_zero) begin
                r_dout <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_underrun <= 1'b0;
            r_bad_ch   <= 1'b0;
        end else begin
            if (w_under)        r_underrun <= 1'b1;
            else if (clr_flags) r_underrun <= 1'b0;
            if (w_bad)          r_bad_ch   <= 1'b1;
            else if (clr_flags) r_bad_ch   <= 1'b0;
        end
    end

    assign in_ready   = w_ready;
    assign D_OUT      = r_dout;
    assign out_strobe = r_strobe;
    assign level      = r_level;
    assign underrun   = r_underrun;
    assign bad_ch     = r_bad_ch;

endmodule

// File: tb/tb_dac_stream_ctrl.sv
module tb_dac_stream_ctrl;

    logic        CLK;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic [0:0]  in_ch;
    logic        enable;
    logic [15:0] rate_div;
    logic        underrun_zero;
    logic        clr_flags;
    logic [19:0] d_out;
    logic [1:0]  out_strobe;
    logic [3:0]  level;
    logic        underrun;
    logic        bad_ch;

    // Second instance with three channels so an out-of-range channel index
    // (3) is representable on a 2-bit in_ch.
    logic        in_valid3;
    logic [1:0]  in_ch3;
    logic        in_ready3;
    logic [29:0] d_out3;
    logic [2:0]  out_strobe3;
    logic [3:0]  level3;
    logic        underrun3;
    logic        bad_ch3;

    int n_tests = 0;
    int n_fail  = 0;

    dac_stream_ctrl #(.DATA_W(10), .NUM_CH(2), .DEPTH(8), .DIV_W(16)) u_dut (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .enable(enable), .rate_div(rate_div), .underrun_zero(underrun_zero),
        .clr_flags(clr_flags), .D_OUT(d_out), .out_strobe(out_strobe),
        .level(level), .underrun(underrun), .bad_ch(bad_ch)
    );

    dac_stream_ctrl #(.DATA_W(10), .NUM_CH(3), .DEPTH(8), .DIV_W(16)) u_dut3 (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data), .in_ch(in_ch3),
        .enable(enable), .rate_div(rate_div), .underrun_zero(underrun_zero),
        .clr_flags(clr_flags), .D_OUT(d_out3), .out_strobe(out_strobe3),
        .level(level3), .underrun(underrun3), .bad_ch(bad_ch3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0;
        enable = 1'b0; rate_div = 16'd3; underrun_zero = 1'b0; clr_flags = 1'b0;
        in_valid3 = 1'b0; in_ch3 = '0;
        #12;
        check("rst_dout", 32'(d_out), 32'h0);
        check("rst_strobe", 32'(out_strobe), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_bad_ch", 32'(bad_ch), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        reset = 1'b1;
        step(1);

        // basic playback, rate_div=3
        in_valid = 1'b1; in_ch = 1'b0; in_data = 10'h155;
        step(1);
        check("basic_level1", 32'(level), 32'd1);
        in_ch = 1'b1; in_data = 10'h2AA;
        step(1);
        in_valid = 1'b0;
        check("basic_level2", 32'(level), 32'd2);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("basic_gap0", 32'(out_strobe), 32'h0);
        end
        step(1);
        check("basic_strobe0", 32'(out_strobe), 32'h1);
        check("basic_ch0", 32'(d_out[9:0]), 32'h155);
        check("basic_lvl_after0", 32'(level), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("basic_gap1", 32'(out_strobe), 32'h0);
        end
        step(1);
        check("basic_strobe1", 32'(out_strobe), 32'h2);
        check("basic_dout", 32'(d_out), 32'hAA955);
        check("basic_lvl_after1", 32'(level), 32'd0);

        // underrun with zeroing
        underrun_zero = 1'b1;
        step(3);
        check("uz_before", 32'(underrun), 32'h0);
        step(1);
        check("uz_flag", 32'(underrun), 32'h1);
        check("uz_dout", 32'(d_out), 32'h0);
        check("uz_strobe", 32'(out_strobe), 32'h0);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("uz_clr", 32'(underrun), 32'h0);

        // underrun with hold
        enable = 1'b0;
        in_valid = 1'b1; in_ch = 1'b0; in_data = 10'h0F0;
        step(1);
        in_ch = 1'b1; in_data = 10'h30F;
        step(1);
        in_valid = 1'b0;
        check("hold_level", 32'(level), 32'd2);
        underrun_zero = 1'b0;
        enable = 1'b1;
        step(4);
        check("hold_pop0", 32'(d_out), 32'h000F0);
        step(4);
        check("hold_pop1", 32'(d_out), 32'hC3CF0);
        step(3);
        check("hold_before", 32'(underrun), 32'h0);
        step(1);
        check("hold_flag", 32'(underrun), 32'h1);
        check("hold_dout", 32'(d_out), 32'hC3CF0);
        check("hold_strobe", 32'(out_strobe), 32'h0);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("hold_clr", 32'(underrun), 32'h0);

        // bad channel on the 3-channel instance
        enable = 1'b0;
        in_valid3 = 1'b1; in_ch3 = 2'd3; in_data = 10'h123;
        step(1);
        check("bad_flag", 32'(bad_ch3), 32'h1);
        check("bad_level", 32'(level3), 32'd0);
        check("bad_strobe", 32'(out_strobe3), 32'h0);
        in_ch3 = 2'd2;
        step(1);
        in_valid3 = 1'b0;
        check("bad_good_level", 32'(level3), 32'd1);
        check("bad_sticky", 32'(bad_ch3), 32'h1);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("bad_clr", 32'(bad_ch3), 32'h0);
        clr_flags = 1'b1; in_valid3 = 1'b1; in_ch3 = 2'd3;
        step(1);
        clr_flags = 1'b0; in_valid3 = 1'b0;
        check("bad_set_wins", 32'(bad_ch3), 32'h1);
        check("bad_level_kept", 32'(level3), 32'd1);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("bad_clr2", 32'(bad_ch3), 32'h0);
        check("bad_dut2_clean", 32'(bad_ch), 32'h0);

        // full FIFO, then ordered drain at one pop per cycle
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_ch = 1'(i % 2); in_data = 10'(32'h100 + i);
            if (i == 7) check("full_ready7", 32'(in_ready), 32'h1);
            if (i == 8) check("full_ready8", 32'(in_ready), 32'h0);
            step(1);
        end
        in_valid = 1'b0;
        check("full_level", 32'(level), 32'd8);
        rate_div = 16'd0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("drain_strobe", 32'(out_strobe), 32'(1 << (i % 2)));
            check("drain_data", 32'((d_out >> (10 * (i % 2))) & 20'h3FF), 32'h100 + i);
            if (i == 0) begin
                check("drain3_strobe", 32'(out_strobe3), 32'h4);
                check("drain3_ch2", 32'(d_out3[29:20]), 32'h123);
            end
        end
        check("drain_level", 32'(level), 32'd0);

        // rate_div lowered below the running count
        rate_div = 16'd7;
        step(4);
        check("rate_cnt4", 32'(underrun), 32'h0);
        rate_div = 16'd2;
        step(1);
        check("rate_wrap", 32'(underrun), 32'h0);
        step(2);
        check("rate_cnt2", 32'(underrun), 32'h0);
        step(1);
        check("rate_tick", 32'(underrun), 32'h1);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("rate_clr", 32'(underrun), 32'h0);

        // rate_div=0 with a continuous push stream
        rate_div = 16'd0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_ch = 1'(i % 2); in_data = 10'(32'h200 + i);
            step(1);
            check("stream_level", 32'(level), 32'd1);
            if (i == 0) begin
                check("stream_first", 32'(out_strobe), 32'h0);
            end else begin
                check("stream_strobe", 32'(out_strobe), 32'(1 << ((i - 1) % 2)));
                check("stream_data", 32'((d_out >> (10 * ((i - 1) % 2))) & 20'h3FF),
                      32'h200 + i - 1);
            end
        end
        in_valid = 1'b0;
        check("stream_no_underrun", 32'(underrun), 32'h0);

        // asynchronous reset mid-period with level=5
        enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in_ch = 1'(j % 2); in_data = 10'(32'h300 + j);
            step(1);
        end
        in_valid = 1'b0;
        check("pre_rst_level", 32'(level), 32'd5);
        enable = 1'b1; rate_div = 16'd7;
        step(2);
        check("pre_rst_level2", 32'(level), 32'd5);
        check("pre_rst_dout", 32'(d_out), 32'h81606);
        #3;
        reset = 1'b0;
        #1;
        check("arst_dout", 32'(d_out), 32'h0);
        check("arst_level", 32'(level), 32'h0);
        check("arst_strobe", 32'(out_strobe), 32'h0);
        check("arst_underrun", 32'(underrun), 32'h0);
        check("arst_bad_ch", 32'(bad_ch), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h1);
        check("arst_level3", 32'(level3), 32'h0);
        #1;
        reset = 1'b1;
        enable = 1'b0;
        in_valid = 1'b1; in_ch = 1'b1; in_data = 10'h3FF;
        step(1);
        in_valid = 1'b0;
        check("resume_level", 32'(level), 32'd1);
        enable = 1'b1; rate_div = 16'd0;
        step(1);
        check("resume_strobe", 32'(out_strobe), 32'h2);
        check("resume_dout", 32'(d_out), 32'hFFC00);
        check("resume_level0", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
